// File: rtl/simon_seq_engine.sv
// Simon pattern engine: LFSR-grown sequence, timed replay, press checking.
// Optional macro SIMON_TIMEOUT_EN adds a READ inactivity timeout.
module simon_seq_engine #(
    parameter int          NUM_BTNS      = 4,
    parameter int          MAX_ROUNDS    = 16,
    parameter int          SHOW_TICKS    = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          TIMEOUT_TICKS = 5
) (
    input  logic                clk_50M,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                start,
    input  logic [NUM_BTNS-1:0] btn_evt,
    output logic [NUM_BTNS-1:0] display_bits,
    output logic                led,
    output logic                playing,
    output logic                win,
    output logic                lose,
    output logic [6:0]          round_len,
    output logic                done_normal
);

    localparam int IW = $clog2(NUM_BTNS);
    localparam int AW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
    localparam logic [6:0] MAX_LEN   = 7'(MAX_ROUNDS);
    localparam logic [7:0] SHOW_LAST = 8'(SHOW_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_GAP,
        S_SHOW,
        S_READ,
        S_NEXT,
        S_WIN,
        S_LOSE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [6:0]    len_d;
    logic [6:0]    rep_q, rep_d;
    logic [6:0]    rd_q, rd_d;
    logic [7:0]    shw_q, shw_d;
    logic          play_d;
    logic          wr_en;
    logic [IW-1:0] new_step;
    logic [NUM_BTNS-1:0] exp_oh;
    logic [NUM_BTNS-1:0] disp_d;

    logic [IW-1:0] pattern [MAX_ROUNDS];

`ifdef SIMON_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_TICKS);
    logic [7:0] to_q, to_d;
`endif

    function automatic logic [NUM_BTNS-1:0] onehot(input logic [IW-1:0] s);
        logic [NUM_BTNS-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    assign new_step = IW'(lfsr_q[7:0] % 8'(NUM_BTNS));
    assign exp_oh   = onehot(pattern[rd_q[AW-1:0]]);

    // Pattern memory is always written before it is read, so it needs no reset.
    always_ff @(posedge clk_50M) begin
        if (wr_en)
            pattern[round_len[AW-1:0]] <= new_step;
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        len_d   = round_len;
        rep_d   = rep_q;
        rd_d    = rd_q;
        shw_d   = shw_q;
        play_d  = playing;
        wr_en   = 1'b0;
`ifdef SIMON_TIMEOUT_EN
        to_d    = to_q;
`endif
        if (tick)
            play_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_APPEND;
            end
            S_APPEND: begin
                wr_en   = 1'b1;
                lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
                len_d   = round_len + 7'd1;
                rep_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (tick) begin
                    if (rep_q == round_len) begin
                        rd_d    = '0;
`ifdef SIMON_TIMEOUT_EN
                        to_d    = '0;
`endif
                        state_d = S_READ;
                    end else begin
                        shw_d   = '0;
                        state_d = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                if (tick) begin
                    if (shw_q == SHOW_LAST) begin
                        rep_d   = rep_q + 7'd1;
                        state_d = S_GAP;
                    end else begin
                        shw_d   = shw_q + 8'd1;
                    end
                end
            end
            S_READ: begin
                // A press wins over a tick arriving in the same cycle.
                if (|btn_evt) begin
                    if (btn_evt == exp_oh) begin
                        rd_d   = rd_q + 7'd1;
                        play_d = 1'b1;
`ifdef SIMON_TIMEOUT_EN
                        to_d   = '0;
`endif
                        if (rd_q + 7'd1 == round_len)
                            state_d = (round_len == MAX_LEN) ? S_WIN : S_NEXT;
                    end else begin
                        state_d = S_LOSE;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (tick) begin
                    to_d = to_q + 8'd1;
                    if (to_q + 8'd1 >= TO_LIMIT)
                        state_d = S_LOSE;
                end
`endif
            end
            S_NEXT: begin
                if (tick)
                    state_d = S_APPEND;
            end
            S_WIN, S_LOSE: begin
                if (start) begin
                    len_d   = '0;
                    rep_d   = '0;
                    rd_d    = '0;
                    state_d = S_APPEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        disp_d = '0;
        if (state_d == S_SHOW)
            disp_d = onehot(pattern[rep_d[AW-1:0]]);
    end

    // Outputs are registered from next-state so they line up with the state.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            round_len    <= '0;
            rep_q        <= '0;
            rd_q         <= '0;
            shw_q        <= '0;
            playing      <= 1'b0;
            display_bits <= '0;
            led          <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
            done_normal  <= 1'b1;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            round_len    <= len_d;
            rep_q        <= rep_d;
            rd_q         <= rd_d;
            shw_q        <= shw_d;
            playing      <= play_d;
            display_bits <= disp_d;
            led          <= (state_d == S_READ);
            win          <= (state_d == S_WIN);
            lose         <= (state_d == S_LOSE);
            done_normal  <= !((state_d == S_GAP) || (state_d == S_SHOW));
        end
    end

`ifdef SIMON_TIMEOUT_EN
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n)
            to_q <= '0;
        else
            to_q <= to_d;
    end
`endif

endmodule

// File: tb/tb_simon_seq_engine.sv
// Scoreboard bench for simon_seq_engine: LFSR model predicts replays.
module tb_simon_seq_engine;

    localparam int NB = 4;
    localparam int MR = 3;

    logic          clk_50M = 1'b0;
    logic          reset_n = 1'b0;
    logic          tick    = 1'b0;
    logic          start   = 1'b0;
    logic [NB-1:0] btn_evt = '0;
    logic [NB-1:0] display_bits;
    logic          led, playing, win, lose, done_normal;
    logic [6:0]    round_len;

    int checks   = 0;
    int failures = 0;

    logic [15:0]   m_lfsr;
    int            m_pat[$];
    logic [NB-1:0] exp_q[$];

    simon_seq_engine #(
        .NUM_BTNS(NB),
        .MAX_ROUNDS(MR),
        .SHOW_TICKS(1),
        .LFSR_SEED(16'hACE1),
        .TIMEOUT_TICKS(5)
    ) dut (
        .clk_50M(clk_50M),
        .reset_n(reset_n),
        .tick(tick),
        .start(start),
        .btn_evt(btn_evt),
        .display_bits(display_bits),
        .led(led),
        .playing(playing),
        .win(win),
        .lose(lose),
        .round_len(round_len),
        .done_normal(done_normal)
    );

    always #10 clk_50M = ~clk_50M;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] oh(input int s);
        logic [NB-1:0] one;
        one = 1;
        return one << s;
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic [15:0] sh;
        sh = v >> 1;
        return v[0] ? (sh ^ 16'hB400) : sh;
    endfunction

    task automatic m_append();
        m_pat.push_back(int'(m_lfsr[7:0]) % NB);
        m_lfsr = lfsr_adv(m_lfsr);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic pulse_tick();
        @(negedge clk_50M) tick = 1'b1;
        @(negedge clk_50M) tick = 1'b0;
        cyc(2);
    endtask

    task automatic pulse_start();
        @(negedge clk_50M) start = 1'b1;
        @(negedge clk_50M) start = 1'b0;
        cyc(2);
    endtask

    task automatic press(input logic [NB-1:0] v);
        @(negedge clk_50M) btn_evt = v;
        @(negedge clk_50M) btn_evt = '0;
    endtask

    task automatic replay();
        int lim;
        foreach (m_pat[i]) exp_q.push_back(oh(m_pat[i]));
        lim = 2 * m_pat.size() + 4;
        for (int t = 0; t < lim && !led; t++) begin
            pulse_tick();
            if (display_bits != '0) begin
                chk_eq("show_done_low", done_normal, 0);
                if (exp_q.size() == 0)
                    chk_eq("extra_step", display_bits, 0);
                else
                    chk_eq("replay_step", display_bits, exp_q.pop_front());
            end
        end
        chk_eq("replay_left", exp_q.size(), 0);
        exp_q.delete();
        chk_eq("read_led", led, 1);
        chk_eq("read_done", done_normal, 1);
        chk_eq("read_disp", display_bits, 0);
        chk_eq("round_len", round_len, m_pat.size());
    endtask

    task automatic play_correct();
        int n;
        n = m_pat.size();
        for (int i = 0; i < n; i++) begin
            press(oh(m_pat[i]));
            chk_eq("playing_on", playing, 1);
            if (i < n - 1) begin
                pulse_tick();
                chk_eq("playing_off", playing, 0);
            end
        end
        if (n < MR)
            m_append();
    endtask

    initial begin
        cyc(3);
        chk_eq("rst_disp", display_bits, 0);
        chk_eq("rst_led", led, 0);
        chk_eq("rst_play", playing, 0);
        chk_eq("rst_win", win, 0);
        chk_eq("rst_lose", lose, 0);
        chk_eq("rst_len", round_len, 0);
        chk_eq("rst_done", done_normal, 1);
        reset_n = 1'b1;
        cyc(2);
        m_lfsr = 16'hACE1;

        // Game 1: win in MR rounds
        pulse_start();
        m_append();
        chk_eq("first_step_model", oh(m_pat[0]), 4'b0010);
        replay();
        pulse_start();
        chk_eq("start_ign_len", round_len, 1);
        chk_eq("start_ign_led", led, 1);
        for (int r = 1; r <= MR; r++) begin
            play_correct();
            if (r < MR) replay();
        end
        chk_eq("win", win, 1);
        chk_eq("win_led", led, 0);
        chk_eq("win_lose", lose, 0);
        chk_eq("win_len", round_len, MR);

        // Game 2: wrong press in round 2
        pulse_start();
        m_pat.delete();
        m_append();
        replay();
        play_correct();
        replay();
        press(oh((m_pat[0] + 1) % NB));
        chk_eq("wrong_lose", lose, 1);
        chk_eq("wrong_led", led, 0);
        chk_eq("wrong_disp", display_bits, 0);
        chk_eq("wrong_win", win, 0);

        // Game 3: multi-bit press
        pulse_start();
        m_pat.delete();
        m_append();
        replay();
        press(4'b0011);
        chk_eq("multi_lose", lose, 1);

        // Game 4: inactivity in READ
        pulse_start();
        m_pat.delete();
        m_append();
        replay();
        play_correct();
        replay();
        repeat (4) pulse_tick();
        chk_eq("to_pre", lose, 0);
        press(oh(m_pat[0]));
        chk_eq("to_press", playing, 1);
        repeat (4) pulse_tick();
        chk_eq("to_restart", lose, 0);
        pulse_tick();
`ifdef SIMON_TIMEOUT_EN
        chk_eq("to_lose", lose, 1);
`else
        chk_eq("no_to_lose", lose, 0);
        chk_eq("no_to_led", led, 1);
`endif

        // Reset mid-replay
        @(negedge clk_50M) reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        m_lfsr = 16'hACE1;
        m_pat.delete();
        pulse_start();
        m_append();
        pulse_tick();
        chk_eq("mid_show", display_bits, oh(m_pat[0]));
        @(negedge clk_50M);
        #3 reset_n = 1'b0;
        #1;
        chk_eq("mid_rst_disp", display_bits, 0);
        chk_eq("mid_rst_len", round_len, 0);
        chk_eq("mid_rst_done", done_normal, 1);
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        m_lfsr = 16'hACE1;
        m_pat.delete();
        pulse_start();
        m_append();
        replay();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simon_seq_engine.md
Name: simon_seq_engine

Overview:
- Parametrised successor to the fixed three-round Simon FSM. Supports NUM_BTNS buttons and MAX_ROUNDS rounds.
- Each round appends one LFSR-generated step to a stored pattern, replays the whole pattern on the display, then checks the player's presses against it.
- Runs on the system clock and uses a 1 Hz tick enable, not a derived clock.
- Sits between debounce_buttons (which supplies single-cycle press events) and the display and sound blocks.

Parameters:
- NUM_BTNS, 4, number of buttons/display segments; legal range 2..8.
- MAX_ROUNDS, 16, pattern length needed to win; legal range 1..64.
- SHOW_TICKS, 1, number of ticks each step stays lit during replay; must be ≥1.
- LFSR_SEED, 16'hACE1, LFSR value after reset; must be nonzero.
- TIMEOUT_TICKS, 5, ticks allowed in READ with no press (used only with the optional feature).

Ports:
- clk_50M  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle enable pulse, 1 Hz.
- start  in  1  one-cycle pulse; begins a game from IDLE, WIN or LOSE.
- btn_evt  in  NUM_BTNS  one-cycle press events from the debouncer.
- display_bits  out  NUM_BTNS  one-hot step being shown, or all zero.
- led  out  1  high while awaiting player input.
- playing  out  1  sound enable, high for one tick after each correct press.
- win  out  1  game won.
- lose  out  1  game lost.
- round_len  out  7  current pattern length.
- done_normal  out  1  low only while the pattern is being shown.

Behaviour:
- Outputs: all registered.
- Reset values: state=IDLE, display_bits=0, led=0, playing=0, win=0, lose=0, round_len=0, done_normal=1, lfsr=LFSR_SEED.
- Reset asserted mid-game: forces the reset values immediately.
- LFSR: 16-bit Galois, mask 16'hB400. It advances one step only when a step is appended.
- Appended step index: lfsr[7:0] % NUM_BTNS, taken from the LFSR value before it advances.
- Pattern store: MAX_ROUNDS entries, each clog2(NUM_BTNS) bits wide.
- States:
  - IDLE:
    - start → APPEND.
    - All other inputs ignored.
  - APPEND (1 cycle):
    - pattern[round_len] ← new step; round_len += 1.
    - Replay index ← 0.
    - Next state: GAP.
  - GAP:
    - display_bits=0, done_normal=0.
    - On tick: if the replay index equals round_len → READ with the read index at 0; otherwise → SHOW.
  - SHOW:
    - display_bits = one-hot of pattern[replay index], done_normal=0.
    - After SHOW_TICKS ticks: replay index += 1 → GAP.
  - READ:
    - led=1, done_normal=1, display_bits=0.
    - btn_evt==0: no action.
    - btn_evt is exactly the one-hot of pattern[read index]: correct press; read index += 1; playing=1 until the next tick.
    - After a correct press, if the read index now equals round_len:
      - round_len==MAX_ROUNDS → WIN;
      - otherwise → APPEND, which is entered on the next tick so the sound completes first.
    - Wrong button, or more than one bit set in btn_evt → LOSE.
    - A tick arriving in the same cycle as a press: the press takes precedence.
  - WIN:
    - win=1, led=0, display_bits=0.
    - start → clear pattern state, round_len=0 → APPEND. The LFSR is not reseeded, so the next game differs.
  - LOSE:
    - lose=1, otherwise the same as WIN.
- start outside IDLE/WIN/LOSE: ignored.
- Latency:
  - start → first SHOW: 1 cycle (APPEND), then the first tick (GAP).
  - Button press → win/lose: 1 cycle.
- Replay timing: SHOW_TICKS+1 ticks per step.

Optional Feature:
- Macro: SIMON_TIMEOUT_EN.
- When defined:
  - A tick counter runs in READ and clears on entry to READ and on each correct press.
  - Reaching TIMEOUT_TICKS ticks without a press → LOSE.
- When undefined:
  - No counter is built; READ waits indefinitely.
  - TIMEOUT_TICKS is unused.

Test Plan:
- Reset sequence (NUM_BTNS=4, LFSR_SEED=16'hACE1):
  - Stimulus: reset_n low, then release; pulse start; apply ticks.
  - Required: all outputs at reset values; round_len=1; display_bits shows one-hot of (8'hE1 % 4 = 1) = 4'b0010 for one tick; then led=1.
- Correct play:
  - Stimulus: press the matching one-hot each round, MAX_ROUNDS=3.
  - Required: playing=1 for one tick after each press; round_len steps 1→2→3; replays match the bench LFSR model; win=1 after the third correct round.
- Wrong press:
  - Stimulus: in round 2 READ, press a non-matching button.
  - Required: lose=1 the next cycle, led=0, display_bits=0.
  - Follow-up: start → round_len=1 and a new step from the continued LFSR.
- Multi-bit press:
  - Stimulus: btn_evt=4'b0011 in READ.
  - Required: LOSE.
- Reset mid-replay:
  - Stimulus: reset_n low during SHOW.
  - Required: display_bits=0 and round_len=0 immediately, state=IDLE, lfsr=16'hACE1.
- Timeout (SIMON_TIMEOUT_EN, TIMEOUT_TICKS=5):
  - Stimulus: no press for 5 ticks in READ.
  - Required: lose=1.
  - Stimulus: a correct press at tick 4.
  - Required: counter restarts.
